uart_axil_bridge: RTL and testbench



---
 rtl/uart_axil_pkg.sv | 30 +++
 rtl/uart_sync_fifo.sv | 48 ++++
 rtl/uart_axil_bridge.sv | 225 ++++++++++++++++++++++
 tb/tb_uart_axil_bridge.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_axil_pkg.sv
// Shared definitions for the UART AXI-Lite bridge: register map, STATUS layout,
// AXI response codes and the TX sequencer state encoding.
package uart_axil_pkg;

    // Register word indices, i.e. byte offset [3:2]
    localparam logic [1:0] REG_TXDATA   = 2'd0;   // 0x0
    localparam logic [1:0] REG_RXDATA   = 2'd1;   // 0x4
    localparam logic [1:0] REG_STATUS   = 2'd2;   // 0x8
    localparam logic [1:0] REG_PRESCALE = 2'd3;   // 0xC

    localparam int ST_TX_EMPTY   = 0;
    localparam int ST_TX_FULL    = 1;
    localparam int ST_RX_EMPTY   = 2;
    localparam int ST_RX_FULL    = 3;
    localparam int ST_RX_OVERRUN = 4;
    localparam int ST_TX_ACTIVE  = 5;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int TX_TIMEOUT = 16;

    typedef enum logic [1:0] {
        TX_IDLE      = 2'd0,
        TX_START     = 2'd1,
        TX_WAIT_BUSY = 2'd2,
        TX_WAIT_DONE = 2'd3
    } tx_state_e;

endpackage

// File: rtl/uart_sync_fifo.sv
// Byte-wide synchronous FIFO. A push while full is accepted only when a pop
// happens in the same cycle; callers that need a stricter rule gate push.
module uart_sync_fifo #(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [7:0]               push_data,
    input  logic                     pop,
    output logic [7:0]               pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_data = mem[rd_ptr];
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);

    // Power-of-two depth lets the pointers wrap by plain overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/uart_axil_bridge.sv
// AXI4-Lite register front end for an external UART core: TX/RX byte FIFOs,
// STATUS/PRESCALE registers and a TX sequencer that hands bytes to the core.
//
// state        | meaning
// TX_IDLE      | waiting for a queued byte and an idle core
// TX_START     | tx_start pulse, tx_data holds the popped byte
// TX_WAIT_BUSY | waiting for the core to raise tx_busy (16-cycle timeout)
// TX_WAIT_DONE | core transmitting, waiting for tx_busy to fall
module uart_axil_bridge
    import uart_axil_pkg::*;
#(
    parameter int          FIFO_DEPTH   = 8,
    parameter logic [15:0] PRESCALE_RST = 16'd868
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  s_awaddr,
    input  logic        s_awvalid,
    output logic        s_awready,
    input  logic [31:0] s_wdata,
    input  logic [3:0]  s_wstrb,
    input  logic        s_wvalid,
    output logic        s_wready,
    output logic [1:0]  s_bresp,
    output logic        s_bvalid,
    input  logic        s_bready,
    input  logic [3:0]  s_araddr,
    input  logic        s_arvalid,
    output logic        s_arready,
    output logic [31:0] s_rdata,
    output logic [1:0]  s_rresp,
    output logic        s_rvalid,
    input  logic        s_rready,
    output logic        tx_start,
    output logic [7:0]  tx_data,
    input  logic        tx_busy,
    input  logic [7:0]  rx_data,
    input  logic        rx_ready,
    output logic [15:0] prescale,
    output logic        irq
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic          ready_en;
    logic          aw_held, w_held;
    logic [1:0]    aw_word;
    logic [31:0]   wdata_q;
    logic [3:0]    wstrb_q;
    logic          aw_hs, w_hs, ar_hs, do_write;
    logic [1:0]    wr_word;
    logic [31:0]   wr_data;
    logic [3:0]    wr_strb;
    logic [15:0]   prescale_q;
    logic          rx_overrun;
    logic          overrun_set;
    logic [31:0]   status_word;
    logic [31:0]   rd_mux;

    logic          tx_push, tx_pop, tx_full, tx_empty;
    logic [7:0]    tx_head;
    logic [CW-1:0] tx_count;
    logic          rx_pop, rx_full, rx_empty;
    logic [7:0]    rx_head;
    logic [CW-1:0] rx_count;

    tx_state_e     state, state_nxt;
    logic [3:0]    timer;
    logic          tx_active;

    uart_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_tx_fifo (
        .clk(clk), .rst_n(rst_n), .push(tx_push), .push_data(wr_data[7:0]),
        .pop(tx_pop), .pop_data(tx_head), .full(tx_full), .empty(tx_empty),
        .count(tx_count)
    );

    uart_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_rx_fifo (
        .clk(clk), .rst_n(rst_n), .push(rx_ready), .push_data(rx_data),
        .pop(rx_pop), .pop_data(rx_head), .full(rx_full), .empty(rx_empty),
        .count(rx_count)
    );

    // ready_en keeps every ready low while in reset
    assign s_awready = ready_en && !aw_held && !s_bvalid;
    assign s_wready  = ready_en && !w_held && !s_bvalid;
    assign s_arready = ready_en && !s_rvalid;
    assign aw_hs     = s_awvalid && s_awready;
    assign w_hs      = s_wvalid && s_wready;
    assign ar_hs     = s_arvalid && s_arready;
    assign do_write  = (aw_held || aw_hs) && (w_held || w_hs);
    assign wr_word   = aw_held ? aw_word : s_awaddr[3:2];
    assign wr_data   = w_held ? wdata_q : s_wdata;
    assign wr_strb   = w_held ? wstrb_q : s_wstrb;

    // TX full check ignores a same-cycle FSM pop
    assign tx_push     = do_write && (wr_word == REG_TXDATA) && wr_strb[0] && !tx_full;
    assign rx_pop      = ar_hs && (s_araddr[3:2] == REG_RXDATA) && !rx_empty;
    assign overrun_set = rx_ready && rx_full && !rx_pop;
    assign prescale    = prescale_q;
    assign irq         = !rx_empty || rx_overrun;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ready_en   <= 1'b0;
            aw_held    <= 1'b0;
            w_held     <= 1'b0;
            aw_word    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            s_bvalid   <= 1'b0;
            s_bresp    <= RESP_OKAY;
            prescale_q <= PRESCALE_RST;
            rx_overrun <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            if (do_write) begin
                aw_held  <= 1'b0;
                w_held   <= 1'b0;
                s_bvalid <= 1'b1;
                s_bresp  <= ((wr_word == REG_TXDATA) && wr_strb[0] && tx_full) ?
                            RESP_SLVERR : RESP_OKAY;
            end else begin
                if (aw_hs) begin
                    aw_held <= 1'b1;
                    aw_word <= s_awaddr[3:2];
                end
                if (w_hs) begin
                    w_held  <= 1'b1;
                    wdata_q <= s_wdata;
                    wstrb_q <= s_wstrb;
                end
                if (s_bvalid && s_bready) s_bvalid <= 1'b0;
            end
            if (do_write && (wr_word == REG_PRESCALE)) begin
                if (wr_strb[0]) prescale_q[7:0]  <= wr_data[7:0];
                if (wr_strb[1]) prescale_q[15:8] <= wr_data[15:8];
            end
            if (overrun_set)
                rx_overrun <= 1'b1;
            else if (do_write && (wr_word == REG_STATUS) && wr_data[ST_RX_OVERRUN])
                rx_overrun <= 1'b0;
        end
    end

    always_comb begin
        status_word                = '0;
        status_word[ST_TX_EMPTY]   = tx_empty;
        status_word[ST_TX_FULL]    = tx_full;
        status_word[ST_RX_EMPTY]   = rx_empty;
        status_word[ST_RX_FULL]    = rx_full;
        status_word[ST_RX_OVERRUN] = rx_overrun;
        status_word[ST_TX_ACTIVE]  = tx_active;
    end

    always_comb begin
        rd_mux = '0;
        case (s_araddr[3:2])
            REG_RXDATA:   rd_mux = rx_empty ? 32'd0 : {23'd0, 1'b1, rx_head};
            REG_STATUS:   rd_mux = status_word;
            REG_PRESCALE: rd_mux = {16'd0, prescale_q};
            default:      rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_rvalid <= 1'b0;
            s_rdata  <= '0;
            s_rresp  <= RESP_OKAY;
        end else if (ar_hs) begin
            s_rvalid <= 1'b1;
            s_rdata  <= rd_mux;
            s_rresp  <= RESP_OKAY;
        end else if (s_rvalid && s_rready) begin
            s_rvalid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= TX_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            TX_IDLE:      if (!tx_empty && !tx_busy) state_nxt = TX_START;
            TX_START:     state_nxt = TX_WAIT_BUSY;
            TX_WAIT_BUSY: if (tx_busy)             state_nxt = TX_WAIT_DONE;
                          else if (timer == '0)    state_nxt = TX_IDLE;
            TX_WAIT_DONE: if (!tx_busy)            state_nxt = TX_IDLE;
            default:      state_nxt = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_start  = 1'b0;
        tx_pop    = 1'b0;
        tx_active = (state != TX_IDLE);
        case (state)
            TX_IDLE:  tx_pop   = !tx_empty && !tx_busy;
            TX_START: tx_start = 1'b1;
            default:  ;
        endcase
    end

    // Down-counter armed in START gives WAIT_BUSY exactly TX_TIMEOUT cycles
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_data <= '0;
            timer   <= '0;
        end else begin
            if (tx_pop) tx_data <= tx_head;
            if (state == TX_START)
                timer <= 4'(TX_TIMEOUT - 1);
            else if ((state == TX_WAIT_BUSY) && (timer != '0))
                timer <= timer - 1'b1;
        end
    end

    logic unused;
    assign unused = &{1'b0, s_awaddr[1:0], s_araddr[1:0], wr_data[31:16],
                      wr_strb[3:2], tx_count, rx_count};

endmodule

// File: tb/tb_uart_axil_bridge.sv
// Directed self-checking bench for uart_axil_bridge with a small UART-core
// stand-in that records tx_start bytes and raises tx_busy afterwards.
module tb_uart_axil_bridge;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  s_awaddr = '0;
    logic        s_awvalid = 1'b0;
    logic        s_awready;
    logic [31:0] s_wdata = '0;
    logic [3:0]  s_wstrb = '0;
    logic        s_wvalid = 1'b0;
    logic        s_wready;
    logic [1:0]  s_bresp;
    logic        s_bvalid;
    logic        s_bready = 1'b0;
    logic [3:0]  s_araddr = '0;
    logic        s_arvalid = 1'b0;
    logic        s_arready;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_rvalid;
    logic        s_rready = 1'b0;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy = 1'b0;
    logic [7:0]  rx_data = '0;
    logic        rx_ready = 1'b0;
    logic [15:0] prescale;
    logic        irq;

    int checks = 0;
    int failures = 0;
    logic [7:0] tx_q[$];
    int  busy_cnt = 0;
    int  busy_len = 4;
    bit  hold_busy = 1'b0;

    uart_axil_bridge dut (
        .clk(clk), .rst_n(rst_n),
        .s_awaddr(s_awaddr), .s_awvalid(s_awvalid), .s_awready(s_awready),
        .s_wdata(s_wdata), .s_wstrb(s_wstrb), .s_wvalid(s_wvalid), .s_wready(s_wready),
        .s_bresp(s_bresp), .s_bvalid(s_bvalid), .s_bready(s_bready),
        .s_araddr(s_araddr), .s_arvalid(s_arvalid), .s_arready(s_arready),
        .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rvalid(s_rvalid), .s_rready(s_rready),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy),
        .rx_data(rx_data), .rx_ready(rx_ready), .prescale(prescale), .irq(irq)
    );

    always #5 clk = ~clk;

    // UART core stand-in: logs each tx_start byte and goes busy for busy_len cycles
    always @(negedge clk) begin
        if (busy_cnt != 0) busy_cnt = busy_cnt - 1;
        if (tx_start) begin
            tx_q.push_back(tx_data);
            busy_cnt = busy_len;
        end
        tx_busy = hold_busy || (busy_cnt != 0);
    end

    task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, output logic [1:0] resp);
        bit aw_done = 0, w_done = 0, aw_hs, w_hs;
        int n = 0;
        @(negedge clk);
        s_awaddr = addr; s_awvalid = 1'b1;
        s_wdata = data; s_wstrb = strb; s_wvalid = 1'b1;
        while (!(aw_done && w_done) && n < 50) begin
            aw_hs = s_awvalid && s_awready;
            w_hs  = s_wvalid && s_wready;
            @(negedge clk); n++;
            if (aw_hs) begin s_awvalid = 1'b0; aw_done = 1; end
            if (w_hs)  begin s_wvalid  = 1'b0; w_done  = 1; end
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        s_bready = 1'b1; n = 0;
        while (!s_bvalid && n < 50) begin @(negedge clk); n++; end
        resp = s_bresp;
        checks++;
        if (!s_bvalid) begin
            failures++;
            $display("FAIL write_timeout addr=%0h bvalid got=0 exp=1", addr);
        end
        @(negedge clk);
        s_bready = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] addr, output logic [31:0] data);
        bit done = 0, hs;
        int n = 0;
        @(negedge clk);
        s_araddr = addr; s_arvalid = 1'b1;
        while (!done && n < 50) begin
            hs = s_arvalid && s_arready;
            @(negedge clk); n++;
            if (hs) begin s_arvalid = 1'b0; done = 1; end
        end
        s_arvalid = 1'b0;
        s_rready = 1'b1; n = 0;
        while (!s_rvalid && n < 50) begin @(negedge clk); n++; end
        data = s_rdata;
        checks++;
        if (!s_rvalid) begin
            failures++;
            $display("FAIL read_timeout addr=%0h rvalid got=0 exp=1", addr);
        end
        @(negedge clk);
        s_rready = 1'b0;
    endtask

    task automatic rx_pulse(input logic [7:0] b);
        @(negedge clk);
        rx_data = b; rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({s_awready, s_wready, s_bvalid, s_arready, s_rvalid} !== 5'b0) begin
            failures++;
            $display("FAIL %s_axi_ctrl got=%b exp=00000", tag,
                     {s_awready, s_wready, s_bvalid, s_arready, s_rvalid});
        end
        checks++;
        if ({s_bresp, s_rresp, s_rdata} !== 36'd0) begin
            failures++;
            $display("FAIL %s_axi_data got bresp=%0h rresp=%0h rdata=%0h exp=0", tag, s_bresp, s_rresp, s_rdata);
        end
        checks++;
        if ({tx_start, tx_data} !== 9'd0) begin
            failures++;
            $display("FAIL %s_tx got start=%0b data=%0h exp=0/00", tag, tx_start, tx_data);
        end
        checks++;
        if (prescale !== 16'd868) begin
            failures++;
            $display("FAIL %s_prescale got=%0d exp=868", tag, prescale);
        end
        checks++;
        if (irq !== 1'b0) begin
            failures++;
            $display("FAIL %s_irq got=%0b exp=0", tag, irq);
        end
    endtask

    task automatic test_reset();
        logic [31:0] rd;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_tx_start got=%0b exp=0", tx_start);
        end
        axi_read(4'h8, rd);
        checks++;
        if (rd !== 32'h05) begin
            failures++;
            $display("FAIL reset_status got=%0h exp=05", rd);
        end
    endtask

    task automatic test_tx_single();
        logic [1:0] resp;
        logic [31:0] rd;
        int n = 0;
        busy_len = 4;
        axi_write(4'h0, 32'hA5, 4'b0001, resp);
        checks++;
        if (resp !== 2'b00) begin
            failures++;
            $display("FAIL tx_single_bresp got=%0h exp=0", resp);
        end
        while (tx_q.size() < 1 && n < 40) begin @(negedge clk); n++; end
        repeat (20) @(negedge clk);
        checks++;
        if (tx_q.size() != 1) begin
            failures++;
            $display("FAIL tx_single_pulses got=%0d exp=1", tx_q.size());
        end else begin
            checks++;
            if (tx_q[0] !== 8'hA5) begin
                failures++;
                $display("FAIL tx_single_data got=%0h exp=a5", tx_q[0]);
            end
        end
        axi_read(4'h8, rd);
        checks++;
        if (rd !== 32'h05) begin
            failures++;
            $display("FAIL tx_single_status got=%0h exp=05", rd);
        end
        tx_q.delete();
    endtask

    task automatic test_tx_fifo_full();
        logic [1:0] resp;
        logic [31:0] rd;
        int n = 0;
        hold_busy = 1'b1;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 9; i++) begin
            axi_write(4'h0, 32'h30 + i, 4'b0001, resp);
            checks++;
            if (resp !== ((i < 8) ? 2'b00 : 2'b10)) begin
                failures++;
                $display("FAIL tx_full_bresp_%0d got=%0h exp=%0h", i, resp, (i < 8) ? 2'b00 : 2'b10);
            end
        end
        axi_read(4'h8, rd);
        checks++;
        if (rd !== 32'h06 || tx_q.size() != 0) begin
            failures++;
            $display("FAIL tx_full_status got=%0h pulses=%0d exp=06 pulses=0", rd, tx_q.size());
        end
        hold_busy = 1'b0;
        while (tx_q.size() < 8 && n < 600) begin @(negedge clk); n++; end
        repeat (30) @(negedge clk);
        checks++;
        if (tx_q.size() != 8) begin
            failures++;
            $display("FAIL tx_full_pulses got=%0d exp=8", tx_q.size());
        end
        for (int i = 0; i < 8 && i < tx_q.size(); i++) begin
            checks++;
            if (tx_q[i] !== 8'(8'h30 + i)) begin
                failures++;
                $display("FAIL tx_full_order_%0d got=%0h exp=%0h", i, tx_q[i], 8'h30 + i);
            end
        end
        tx_q.delete();
    endtask

    task automatic test_rx();
        logic [31:0] rd;
        rx_pulse(8'h3C);
        checks++;
        if (irq !== 1'b1) begin failures++; $display("FAIL rx_irq_set got=%0b exp=1", irq); end
        axi_read(4'h4, rd);
        checks++;
        if (rd !== 32'h13C) begin failures++; $display("FAIL rx_read1 got=%0h exp=13c", rd); end
        checks++;
        if (irq !== 1'b0) begin failures++; $display("FAIL rx_irq_clr got=%0b exp=0", irq); end
        axi_read(4'h4, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL rx_read_empty got=%0h exp=0", rd); end
    endtask

    task automatic test_rx_overrun();
        logic [31:0] rd;
        logic [1:0]  resp;
        int n = 0;
        for (int i = 0; i < 9; i++) rx_pulse(8'h50 + 8'(i));
        axi_read(4'h8, rd);
        checks++;
        if (rd !== 32'h19) begin failures++; $display("FAIL ovr_status got=%0h exp=19", rd); end
        axi_write(4'h8, 32'h10, 4'b0001, resp);
        axi_read(4'h8, rd);
        checks++;
        if (rd !== 32'h09 || resp !== 2'b00) begin
            failures++;
            $display("FAIL ovr_w1c got=%0h resp=%0h exp=09 resp=0", rd, resp);
        end
        // pop and push on the full RX FIFO in the same cycle
        @(negedge clk);
        s_araddr = 4'h4; s_arvalid = 1'b1; rx_data = 8'hEE; rx_ready = 1'b1;
        @(negedge clk);
        s_arvalid = 1'b0; rx_ready = 1'b0; s_rready = 1'b1;
        while (!s_rvalid && n < 20) begin @(negedge clk); n++; end
        rd = s_rdata;
        @(negedge clk);
        s_rready = 1'b0;
        checks++;
        if (rd !== 32'h150) begin failures++; $display("FAIL ovr_simul_read got=%0h exp=150", rd); end
        axi_read(4'h8, rd);
        checks++;
        if (rd !== 32'h09) begin failures++; $display("FAIL ovr_simul_status got=%0h exp=09", rd); end
        for (int i = 1; i < 9; i++) begin
            axi_read(4'h4, rd);
            checks++;
            if (rd !== ((i < 8) ? 32'h150 + i : 32'h1EE)) begin
                failures++;
                $display("FAIL ovr_drain_%0d got=%0h exp=%0h", i, rd, (i < 8) ? 32'h150 + i : 32'h1EE);
            end
        end
        axi_read(4'h8, rd);
        checks++;
        if (rd !== 32'h05 || irq !== 1'b0) begin
            failures++;
            $display("FAIL ovr_final got status=%0h irq=%0b exp=05/0", rd, irq);
        end
    endtask

    task automatic test_prescale();
        logic [1:0]  resp;
        logic [31:0] rd;
        axi_write(4'hC, 32'd10416, 4'b0011, resp);
        checks++;
        if (prescale !== 16'd10416) begin failures++; $display("FAIL pre_full_out got=%0d exp=10416", prescale); end
        axi_read(4'hC, rd);
        checks++;
        if (rd !== 32'd10416) begin failures++; $display("FAIL pre_full_rd got=%0d exp=10416", rd); end
        axi_write(4'hC, 32'd100, 4'b0001, resp);
        axi_read(4'hC, rd);
        checks++;
        if (rd !== 32'd10340 || prescale !== 16'd10340) begin
            failures++;
            $display("FAIL pre_low_byte got rd=%0d out=%0d exp=10340", rd, prescale);
        end
        axi_write(4'hF, 32'h0000_1234, 4'b0011, resp);
        checks++;
        if (prescale !== 16'h1234) begin failures++; $display("FAIL pre_addr_lsb got=%0h exp=1234", prescale); end
        axi_read(4'h0, rd);
        checks++;
        if (rd !== 32'h0) begin failures++; $display("FAIL txdata_read got=%0h exp=0", rd); end
        axi_write(4'h4, 32'hFF, 4'b1111, resp);
        axi_read(4'h8, rd);
        checks++;
        if (resp !== 2'b00 || rd !== 32'h05) begin
            failures++;
            $display("FAIL rxdata_write got resp=%0h status=%0h exp=0/05", resp, rd);
        end
    endtask

    task automatic test_back_to_back_reset();
        logic [31:0] rd;
        bit stable = 1;
        int n = 0;
        busy_len = 40;
        @(negedge clk);
        s_awaddr = 4'h0; s_awvalid = 1'b1; s_wdata = 32'h5A; s_wstrb = 4'b0001;
        checks++;
        if (s_awready !== 1'b1) begin failures++; $display("FAIL b2b_awready got=%0b exp=1", s_awready); end
        @(negedge clk);
        s_awvalid = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({s_awready, s_bvalid, s_wready} !== 3'b001) begin
            failures++;
            $display("FAIL b2b_aw_held got=%b exp=001", {s_awready, s_bvalid, s_wready});
        end
        s_wvalid = 1'b1;
        @(negedge clk);
        s_wvalid = 1'b0;
        checks++;
        if (s_bvalid !== 1'b1 || s_bresp !== 2'b00) begin
            failures++;
            $display("FAIL b2b_bvalid got=%0b resp=%0h exp=1/0", s_bvalid, s_bresp);
        end
        s_wdata = 32'h77; s_awvalid = 1'b1; s_wvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (!s_bvalid || s_bresp !== 2'b00 || s_awready || s_wready) stable = 0;
        end
        s_awvalid = 1'b0; s_wvalid = 1'b0;
        checks++;
        if (!stable) begin failures++; $display("FAIL b2b_hold got stable=0 exp=1"); end
        s_bready = 1'b1;
        @(negedge clk);
        s_bready = 1'b0;
        checks++;
        if (s_bvalid !== 1'b0) begin failures++; $display("FAIL b2b_bdone got=%0b exp=0", s_bvalid); end
        while (tx_q.size() < 1 && n < 30) begin @(negedge clk); n++; end
        repeat (4) @(negedge clk);
        axi_read(4'h8, rd);
        checks++;
        if (rd !== 32'h25 || tx_q.size() != 1 || tx_busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_wait_done got status=%0h pulses=%0d exp=25 pulses=1", rd, tx_q.size());
        end else begin
            checks++;
            if (tx_q[0] !== 8'h5A) begin failures++; $display("FAIL b2b_data got=%0h exp=5a", tx_q[0]); end
        end
        // reset while the sequencer sits in WAIT_DONE
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (tx_start !== 1'b0) begin failures++; $display("FAIL midreset_release got=%0b exp=0", tx_start); end
        repeat (20) @(negedge clk);
        axi_read(4'h8, rd);
        checks++;
        if (rd !== 32'h05 || tx_q.size() != 1) begin
            failures++;
            $display("FAIL midreset_status got=%0h pulses=%0d exp=05 pulses=1", rd, tx_q.size());
        end
        tx_q.delete();
    endtask

    initial begin
        test_reset();
        test_tx_single();
        test_tx_fifo_full();
        test_rx();
        test_rx_overrun();
        test_prescale();
        test_back_to_back_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
